// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: FETCH/DECODE/EXE/MEM/WB/BRANCH/JUMP sequencing,
// datapath control decode, illegal-instruction flag and retired-instruction counter.
module multi_cycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  funct,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWr,
  output logic        IRWr,
  output logic [1:0]  PCSrc,
  output logic        RegDst,
  output logic        RegW,
  output logic        MemR,
  output logic        MemW,
  output logic        Mem2R,
  output logic        IorD,
  output logic        AluSrcA,
  output logic [1:0]  AluSrcB,
  output logic [1:0]  ExtOp,
  output logic [4:0]  Aluctrl,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB_ALU = 4'd5,
    S_WB_MEM = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [4:0] ALUOP_ADDU = 5'd0;
  localparam logic [4:0] ALUOP_SUBU = 5'd1;
  localparam logic [4:0] ALUOP_ADD  = 5'd2;
  localparam logic [4:0] ALUOP_SUB  = 5'd3;
  localparam logic [4:0] ALUOP_AND  = 5'd4;
  localparam logic [4:0] ALUOP_OR   = 5'd5;
  localparam logic [4:0] ALUOP_SLL  = 5'd6;
  localparam logic [4:0] ALUOP_SRL  = 5'd7;
  localparam logic [4:0] ALUOP_SLT  = 5'd8;
  localparam logic [4:0] ALUOP_EQL  = 5'd9;
  localparam logic [4:0] ALUOP_BNE  = 5'd10;

  localparam logic [1:0] EXT_ZERO    = 2'd0;
  localparam logic [1:0] EXT_SIGNED  = 2'd1;
  localparam logic [1:0] EXT_HIGHPOS = 2'd2;

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [5:0]  funct_q, funct_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic        retire;

  function automatic logic r_funct_ok(input logic [5:0] f);
    case (f)
      6'b100001, 6'b100011, 6'b100000, 6'b100010, 6'b100100,
      6'b100101, 6'b000000, 6'b000010, 6'b101010: r_funct_ok = 1'b1;
      default:                                    r_funct_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] r_alu(input logic [5:0] f);
    case (f)
      6'b100001: r_alu = ALUOP_ADDU;
      6'b100011: r_alu = ALUOP_SUBU;
      6'b100010: r_alu = ALUOP_SUB;
      6'b100100: r_alu = ALUOP_AND;
      6'b100101: r_alu = ALUOP_OR;
      6'b000000: r_alu = ALUOP_SLL;
      6'b000010: r_alu = ALUOP_SRL;
      6'b101010: r_alu = ALUOP_SLT;
      default:   r_alu = ALUOP_ADD;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    funct_d     = funct_q;
    retire      = 1'b0;
    PCWr        = 1'b0;
    IRWr        = 1'b0;
    PCSrc       = 2'b00;
    RegDst      = 1'b0;
    RegW        = 1'b0;
    MemR        = 1'b0;
    MemW        = 1'b0;
    Mem2R       = 1'b0;
    IorD        = 1'b0;
    AluSrcA     = 1'b0;
    AluSrcB     = 2'b00;
    ExtOp       = EXT_ZERO;
    Aluctrl     = ALUOP_ADD;
    illegal     = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemR    = 1'b1;
        AluSrcB = 2'b01;
        Aluctrl = ALUOP_ADDU;
        PCWr    = mem_ready;
        IRWr    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // IR is stable here, so decode straight from OpCode/funct and latch them.
        op_d    = OpCode;
        funct_d = funct;
        AluSrcB = 2'b10;
        ExtOp   = EXT_SIGNED;
        Aluctrl = ALUOP_ADD;
        case (OpCode)
          OP_R: begin
            if (r_funct_ok(funct)) state_d = S_EXE;
            else begin
              state_d = S_FETCH;
              illegal = 1'b1;
            end
          end
          OP_ADDI, OP_ORI, OP_SLTI, OP_LUI, OP_LW, OP_SW: state_d = S_EXE;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_EXE: begin
        AluSrcA = 1'b1;
        case (op_q)
          OP_R: Aluctrl = r_alu(funct_q);
          OP_ADDI, OP_LW, OP_SW: begin
            AluSrcB = 2'b10;
            ExtOp   = EXT_SIGNED;
          end
          OP_SLTI: begin
            AluSrcB = 2'b10;
            ExtOp   = EXT_SIGNED;
            Aluctrl = ALUOP_SLT;
          end
          OP_ORI: begin
            AluSrcB = 2'b10;
            Aluctrl = ALUOP_OR;
          end
          OP_LUI: begin
            AluSrcB = 2'b10;
            ExtOp   = EXT_HIGHPOS;
            Aluctrl = ALUOP_ADDU;
          end
          default: ;
        endcase
        if (op_q == OP_LW)      state_d = S_MEM_RD;
        else if (op_q == OP_SW) state_d = S_MEM_WR;
        else                    state_d = S_WB_ALU;
      end
      S_MEM_RD: begin
        MemR = 1'b1;
        IorD = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        MemW = 1'b1;
        IorD = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WB_ALU: begin
        RegW    = 1'b1;
        RegDst  = (op_q == OP_R);
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_WB_MEM: begin
        RegW    = 1'b1;
        Mem2R   = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        AluSrcA = 1'b1;
        PCSrc   = 2'b01;
        PCWr    = Zero;
        Aluctrl = (op_q == OP_BNE) ? ALUOP_BNE : ALUOP_EQL;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWr    = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    instr_cnt_d = retire ? instr_cnt_q + 32'd1 : instr_cnt_q;

    // Architectural side effects are suppressed for the whole reset assertion.
    if (!rst) begin
      PCWr    = 1'b0;
      IRWr    = 1'b0;
      RegW    = 1'b0;
      MemW    = 1'b0;
      illegal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      op_q        <= 6'd0;
      funct_q     <= 6'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      funct_q     <= funct_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign state     = state_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-cycle state/control vectors compared against
// hand-written expectations for each instruction class, reset and counter wrap.
module tb_multi_cycle_ctrl;

  localparam logic [4:0] ADDU = 5'd0, SUBU = 5'd1, ADD = 5'd2, SUB = 5'd3, AND_ = 5'd4,
                         OR_ = 5'd5, SLL = 5'd6, SRL = 5'd7, SLT = 5'd8, EQL = 5'd9, BNE = 5'd10;
  localparam logic [1:0] EZ = 2'd0, ES = 2'd1, EH = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  OpCode, funct;
  logic        Zero, mem_ready;
  logic        PCWr, IRWr, RegDst, RegW, MemR, MemW, Mem2R, IorD, AluSrcA, illegal;
  logic [1:0]  PCSrc, AluSrcB, ExtOp;
  logic [4:0]  Aluctrl;
  logic [3:0]  state;
  logic [31:0] instr_cnt;
  logic [24:0] obs;
  logic [31:0] exp_cnt;
  int          errors = 0;
  int          checks = 0;

  multi_cycle_ctrl dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .funct(funct), .Zero(Zero), .mem_ready(mem_ready),
    .PCWr(PCWr), .IRWr(IRWr), .PCSrc(PCSrc), .RegDst(RegDst), .RegW(RegW), .MemR(MemR),
    .MemW(MemW), .Mem2R(Mem2R), .IorD(IorD), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
    .ExtOp(ExtOp), .Aluctrl(Aluctrl), .state(state), .illegal(illegal), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {state, PCWr, IRWr, PCSrc, RegDst, RegW, MemR, MemW, Mem2R, IorD,
                AluSrcA, AluSrcB, ExtOp, Aluctrl, illegal};

  // Expected-vector builder in the same field order as obs.
  function automatic logic [24:0] w(input logic [3:0] st, input logic pcwr, irwr,
                                    input logic [1:0] pcsrc, input logic regdst, regw, memr,
                                    memw, mem2r, iord, srca, input logic [1:0] srcb, ext,
                                    input logic [4:0] alu, input logic ill);
    w = {st, pcwr, irwr, pcsrc, regdst, regw, memr, memw, mem2r, iord, srca, srcb, ext, alu, ill};
  endfunction

  function automatic logic [24:0] v_fetch(input logic rdy);
    v_fetch = w(4'd0, rdy, rdy, 2'd0, 0, 0, 1, 0, 0, 0, 0, 2'd1, EZ, ADDU, 0);
  endfunction

  function automatic logic [24:0] v_decode(input logic ill);
    v_decode = w(4'd1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd2, ES, ADD, ill);
  endfunction

  task automatic test_reset();
    rst = 1'b0; mem_ready = 1'b1; OpCode = 6'd0; funct = 6'd0; Zero = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== w(4'd0, 0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 2'd1, EZ, ADDU, 0)) begin
      errors++; $display("FAIL reset_ctrl got %h want fetch-gated", obs);
    end
    checks++;
    if (instr_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got %h want 0", instr_cnt);
    end
    rst = 1'b1; Zero = 1'b0;
    exp_cnt = 32'd0;
  endtask

  task automatic test_rtype();
    logic [5:0]  fn  [9] = '{6'b100000, 6'b100001, 6'b100011, 6'b100010, 6'b100100,
                             6'b100101, 6'b000000, 6'b000010, 6'b101010};
    logic [4:0]  alu [9] = '{ADD, ADDU, SUBU, SUB, AND_, OR_, SLL, SRL, SLT};
    logic [24:0] ex  [4];
    for (int k = 0; k < 9; k++) begin
      OpCode = 6'b000000; funct = fn[k]; mem_ready = 1'b1;
      ex[0] = v_fetch(1);
      ex[1] = v_decode(0);
      ex[2] = w(4'd2, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 2'd0, EZ, alu[k], 0);
      ex[3] = w(4'd5, 0, 0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 2'd0, EZ, ADD, 0);
      for (int i = 0; i < 4; i++) begin
        #1;
        checks++;
        if (obs !== ex[i]) begin
          errors++; $display("FAIL rtype f=%b cyc%0d got %h want %h", fn[k], i, obs, ex[i]);
        end
        @(posedge clk); #1;
      end
      exp_cnt++;
      checks++;
      if ({state, instr_cnt} !== {4'd0, exp_cnt}) begin
        errors++; $display("FAIL rtype_retire got st=%0d cnt=%0d want st=0 cnt=%0d", state, instr_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_itype();
    logic [5:0]  op  [4] = '{6'b001000, 6'b001101, 6'b001010, 6'b001111};
    logic [4:0]  alu [4] = '{ADD, OR_, SLT, ADDU};
    logic [1:0]  ext [4] = '{ES, EZ, ES, EH};
    logic [24:0] ex  [4];
    for (int k = 0; k < 4; k++) begin
      OpCode = op[k]; funct = 6'b111111; mem_ready = 1'b1;
      ex[0] = v_fetch(1);
      ex[1] = v_decode(0);
      ex[2] = w(4'd2, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 2'd2, ext[k], alu[k], 0);
      ex[3] = w(4'd5, 0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 2'd0, EZ, ADD, 0);
      for (int i = 0; i < 4; i++) begin
        #1;
        checks++;
        if (obs !== ex[i]) begin
          errors++; $display("FAIL itype op=%b cyc%0d got %h want %h", op[k], i, obs, ex[i]);
        end
        @(posedge clk); #1;
      end
      exp_cnt++;
      checks++;
      if ({state, instr_cnt} !== {4'd0, exp_cnt}) begin
        errors++; $display("FAIL itype_retire got st=%0d cnt=%0d want st=0 cnt=%0d", state, instr_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_load();
    logic        rdy [7] = '{1, 1, 1, 0, 0, 1, 0};
    logic [24:0] ex  [7];
    OpCode = 6'b100011; funct = 6'd0;
    ex[0] = v_fetch(1);
    ex[1] = v_decode(0);
    ex[2] = w(4'd2, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 2'd2, ES, ADD, 0);
    ex[3] = w(4'd3, 0, 0, 2'd0, 0, 0, 1, 0, 0, 1, 0, 2'd0, EZ, ADD, 0);
    ex[4] = ex[3];
    ex[5] = ex[3];
    ex[6] = w(4'd6, 0, 0, 2'd0, 0, 1, 0, 0, 1, 0, 0, 2'd0, EZ, ADD, 0);
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL load cyc%0d got %h want %h", i, obs, ex[i]);
      end
      @(posedge clk); #1;
    end
    exp_cnt++;
    checks++;
    if ({state, instr_cnt} !== {4'd0, exp_cnt}) begin
      errors++; $display("FAIL load_retire got st=%0d cnt=%0d want st=0 cnt=%0d", state, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_branch();
    logic [5:0]  op [3] = '{6'b000100, 6'b000100, 6'b000101};
    logic        z  [3] = '{1, 0, 1};
    logic [24:0] ex [3];
    for (int k = 0; k < 3; k++) begin
      OpCode = op[k]; Zero = z[k]; mem_ready = 1'b1;
      ex[0] = v_fetch(1);
      ex[1] = v_decode(0);
      ex[2] = w(4'd7, z[k], 0, 2'd1, 0, 0, 0, 0, 0, 0, 1, 2'd0, EZ, (k == 2) ? BNE : EQL, 0);
      for (int i = 0; i < 3; i++) begin
        #1;
        checks++;
        if (obs !== ex[i]) begin
          errors++; $display("FAIL branch k=%0d cyc%0d got %h want %h", k, i, obs, ex[i]);
        end
        @(posedge clk); #1;
      end
      exp_cnt++;
      checks++;
      if ({state, instr_cnt} !== {4'd0, exp_cnt}) begin
        errors++; $display("FAIL branch_retire got st=%0d cnt=%0d want st=0 cnt=%0d", state, instr_cnt, exp_cnt);
      end
    end
    Zero = 1'b0;
  endtask

  task automatic test_illegal();
    logic [5:0] op [2] = '{6'b111111, 6'b000000};
    logic [5:0] fn [2] = '{6'b000000, 6'b111111};
    for (int k = 0; k < 2; k++) begin
      OpCode = op[k]; funct = fn[k]; mem_ready = 1'b1;
      #1;
      checks++;
      if (obs !== v_fetch(1)) begin
        errors++; $display("FAIL illegal_fetch k=%0d got %h want %h", k, obs, v_fetch(1));
      end
      @(posedge clk); #1;
      checks++;
      if (obs !== v_decode(1)) begin
        errors++; $display("FAIL illegal_decode k=%0d got %h want %h", k, obs, v_decode(1));
      end
      @(posedge clk); #1;
      checks++;
      if ({state, illegal, instr_cnt} !== {4'd0, 1'b0, exp_cnt}) begin
        errors++; $display("FAIL illegal_after k=%0d got st=%0d ill=%b cnt=%0d want st=0 ill=0 cnt=%0d",
                           k, state, illegal, instr_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_store_reset();
    logic        rdy [5] = '{1, 1, 1, 0, 1};
    logic [24:0] ex  [5];
    OpCode = 6'b101011; funct = 6'd0;
    ex[0] = v_fetch(1);
    ex[1] = v_decode(0);
    ex[2] = w(4'd2, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 2'd2, ES, ADD, 0);
    ex[3] = w(4'd4, 0, 0, 2'd0, 0, 0, 0, 1, 0, 1, 0, 2'd0, EZ, ADD, 0);
    ex[4] = ex[3];
    for (int i = 0; i < 5; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL store cyc%0d got %h want %h", i, obs, ex[i]);
      end
      @(posedge clk); #1;
    end
    exp_cnt++;
    checks++;
    if ({state, instr_cnt} !== {4'd0, exp_cnt}) begin
      errors++; $display("FAIL store_retire got st=%0d cnt=%0d want st=0 cnt=%0d", state, instr_cnt, exp_cnt);
    end
    // Second store is abandoned by reset while waiting in MEM_WR.
    for (int i = 0; i < 4; i++) begin
      mem_ready = rdy[i];
      @(posedge clk); #1;
    end
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if (obs !== w(4'd4, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 2'd0, EZ, ADD, 0)) begin
      errors++; $display("FAIL store_rst_hold got %h want MEM_WR with MemW gated", obs);
    end
    @(posedge clk); #1;
    exp_cnt = 32'd0;
    checks++;
    if ({state, MemW, instr_cnt} !== {4'd0, 1'b0, exp_cnt}) begin
      errors++; $display("FAIL store_rst got st=%0d MemW=%b cnt=%0d want st=0 MemW=0 cnt=0", state, MemW, instr_cnt);
    end
    rst = 1'b1;
  endtask

  task automatic test_jump_wrap();
    logic        rdy [4] = '{0, 1, 1, 1};
    logic [24:0] ex  [4];
    OpCode = 6'b000010; funct = 6'd0; mem_ready = 1'b0;
    force dut.instr_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.instr_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (instr_cnt !== exp_cnt) begin
      errors++; $display("FAIL wrap_preset got %h want %h", instr_cnt, exp_cnt);
    end
    ex[0] = v_fetch(0);
    ex[1] = v_fetch(1);
    ex[2] = v_decode(0);
    ex[3] = w(4'd8, 1, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, EZ, ADD, 0);
    for (int i = 0; i < 4; i++) begin
      mem_ready = rdy[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL jump cyc%0d got %h want %h", i, obs, ex[i]);
      end
      @(posedge clk); #1;
    end
    exp_cnt = 32'd0;
    checks++;
    if ({state, instr_cnt} !== {4'd0, exp_cnt}) begin
      errors++; $display("FAIL wrap got st=%0d cnt=%h want st=0 cnt=0", state, instr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_load();
    test_branch();
    test_illegal();
    test_store_reset();
    test_jump_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-low; sampled only on the rising clk edge.
REQ-003 OpCode  in  6  instruction opcode field, from IR; stable from DECODE until the next FETCH.
REQ-004 funct  in  6  instruction function field, from IR.
REQ-005 Zero  in  1  ALU condition flag; 1 = branch condition true for the current ALUOp_EQL or ALUOp_BNE.
REQ-006 mem_ready  in  1  memory handshake; 1 = current read or write completes this cycle.
REQ-007 PCWr, IRWr  out  1 each  PC write enable; IR write enable.
REQ-008 PCSrc  out  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = jump target.
REQ-009 RegDst, RegW, MemR, MemW, Mem2R, IorD  out  1 each  datapath controls; IorD 0 = PC address, 1 = ALU-out address.
REQ-010 AluSrcA  out  1  0 = PC, 1 = rs.
REQ-011 AluSrcB  out  2  00 = rt, 01 = constant 4, 10 = extended immediate.
REQ-012 ExtOp  out  2  EXT_ZERO, EXT_SIGNED or EXT_HIGHPOS codes.
REQ-013 Aluctrl  out  5  ALUOp_* code.
REQ-014 state  out  4  current state encoding, for debug.
REQ-015 illegal  out  1  one-cycle pulse when an undecodable instruction is detected.
REQ-016 instr_cnt  out  32  count of retired instructions.

Function
REQ-017 States and encodings: FETCH=0, DECODE=1, EXE=2, MEM_RD=3, MEM_WR=4, WB_ALU=5, WB_MEM=6, BRANCH=7, JUMP=8. Codes 9-15 go to FETCH on the next edge.
REQ-018 All outputs are combinational from the registered state and the latched op/funct only.
- No output depends on mem_ready, except PCWr and IRWr in FETCH.
- No output depends on Zero, except PCWr in BRANCH.
REQ-019 FETCH:
- Controls: MemR=1, IorD=0, AluSrcA=0, AluSrcB=01, Aluctrl=ALUOp_ADDU, PCSrc=00.
- PCWr=IRWr=mem_ready.
- Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-020 DECODE:
- Capture OpCode/funct into internal op_q/funct_q.
- Controls: AluSrcA=0, AluSrcB=10, ExtOp=EXT_SIGNED, Aluctrl=ALUOp_ADD (branch target).
- Next state: R-type/addi/ori/slti/lui/lw/sw -> EXE; beq/bne -> BRANCH; j -> JUMP; anything else -> FETCH with illegal=1.
REQ-021 Decode values:
- Opcodes: R=000000, addi=001000, ori=001101, slti=001010, lui=001111, lw=100011, sw=101011, beq=000100, bne=000101, j=000010.
- R-type funct: addu=100001, subu=100011, add=100000, sub=100010, and=100100, or=100101, sll=000000, srl=000010, slt=101010.
- Any other funct under R-type is illegal.
REQ-022 EXE:
- Common controls: AluSrcA=1.
- R-type: AluSrcB=00, Aluctrl per funct (ALUOp_ADDU/SUBU/ADD/SUB/AND/OR/SLL/SRL/SLT).
- addi/slti/lw/sw: AluSrcB=10, ExtOp=EXT_SIGNED; Aluctrl ALUOp_ADD (addi/lw/sw) or ALUOp_SLT (slti).
- ori: AluSrcB=10, ExtOp=EXT_ZERO, Aluctrl=ALUOp_OR.
- lui: AluSrcB=10, ExtOp=EXT_HIGHPOS, Aluctrl=ALUOp_ADDU.
- Next state: lw -> MEM_RD; sw -> MEM_WR; others -> WB_ALU.
REQ-023 MEM_RD:
- Controls: MemR=1, IorD=1.
- Hold while mem_ready=0; go to WB_MEM when mem_ready=1.
REQ-024 MEM_WR:
- Controls: MemW=1, IorD=1.
- Hold while mem_ready=0; go to FETCH when mem_ready=1 (retire).
REQ-025 WB_ALU:
- Controls: RegW=1, Mem2R=0; RegDst=1 for R-type, else 0.
- Next state FETCH (retire).
REQ-026 WB_MEM:
- Controls: RegW=1, Mem2R=1, RegDst=0.
- Next state FETCH (retire).
REQ-027 BRANCH:
- Controls: AluSrcA=1, AluSrcB=00, PCSrc=01, PCWr=Zero.
- Aluctrl: ALUOp_EQL for beq, ALUOp_BNE for bne.
- Next state FETCH (retire).
REQ-028 JUMP:
- Controls: PCSrc=10, PCWr=1.
- Next state FETCH (retire).
REQ-029 Any control not listed for a state is 0. Aluctrl defaults to ALUOp_ADD; ExtOp defaults to EXT_ZERO.
REQ-030 Zero-wait latencies (mem_ready held at 1):
- R/I-ALU: 4 cycles; lw: 5; sw: 4; beq/bne: 3; j: 3.
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
REQ-031 instr_cnt:
- Increments by 1 on the edge leaving a retiring state; wraps 0xFFFFFFFF -> 0.
- Illegal instructions are not counted.
REQ-032 MemR and MemW are never both 1; IRWr=1 only in FETCH.

Reset
REQ-033 rst=0 at a clk edge sets state=FETCH, op_q=funct_q=0, instr_cnt=0.
- Takes priority over every transition, including mid-handshake in MEM_RD or MEM_WR.
- A pending memory access is abandoned.
REQ-034 While rst=0, PCWr=IRWr=RegW=MemW=0 and illegal=0, regardless of mem_ready.
REQ-035 The first FETCH begins on the first edge with rst=1.

Verification
REQ-036 add (op 000000, funct 100000), mem_ready=1 -> states 0,1,2,5,0; Aluctrl=ALUOp_ADD in EXE; RegW=RegDst=1 for exactly one cycle; instr_cnt +1.
REQ-037 lw (100011), mem_ready low 2 cycles in MEM_RD -> states 0,1,2,3,3,3,6,0 (7 cycles); Mem2R=RegW=1 only in WB_MEM.
REQ-038 beq (000100), Zero=1 in BRANCH -> PCWr=1, PCSrc=01; repeat with Zero=0 -> PCWr=0; both take 3 cycles and are counted.
REQ-039 opcode 111111 -> illegal=1 for one cycle in DECODE, next state FETCH, instr_cnt unchanged.
REQ-040 rst=0 asserted during MEM_WR with mem_ready=0 -> next edge state=0, MemW=0, instr_cnt=0.
REQ-041 instr_cnt preset to 0xFFFFFFFF, retire j (000010) -> instr_cnt=0; PCSrc=10 and PCWr=1 in JUMP.
